// File: rtl/bitstream_loader.sv
// Word-to-serial loader feeding a CLB row programming shift chain.
// Streams 32-bit words LSB-first onto prog_in/prog_en for CHAIN_LEN bits.
module bitstream_loader #(
    parameter  int CHAIN_LEN = 552,
    parameter  int WORD_W    = 32,
    localparam int BCW       = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_rst,
    input  logic              start,
    input  logic              abort,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              prog_in,
    output logic              prog_en,
    output logic              busy,
    output logic              done,
    output logic [BCW-1:0]    bit_count
);

    localparam int             WBW  = $clog2(WORD_W + 1);
    localparam logic [BCW-1:0] LAST = BCW'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [WORD_W-1:0] sbuf;
    logic [WBW-1:0]    wbits;
    logic [WBW-1:0]    wbits_ld;
    logic [BCW-1:0]    bc_nx;
    logic [BCW-1:0]    rem;
    logic              accept;
    logic              last_bit;
    logic              final_bit;

    // Bits left in the chain after this edge bound the incoming word length.
    always_comb begin
        last_bit  = (wbits == WBW'(1));
        final_bit = (bit_count == LAST);
        bc_nx     = (state == SHIFT) ? bit_count + BCW'(1) : bit_count;
        rem       = BCW'(CHAIN_LEN) - bc_nx;
        wbits_ld  = (32'(rem) >= 32'(WORD_W)) ? WBW'(WORD_W) : WBW'(rem);
    end

    always_ff @(posedge prog_clk) begin
        if (prog_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        word_ready = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = LOAD;
            end
            LOAD: begin
                word_ready = 1'b1;
                if (word_valid) state_nx = SHIFT;
            end
            SHIFT: begin
                if (final_bit) begin
                    state_nx = DONE;
                end else if (last_bit) begin
                    word_ready = 1'b1;
                    state_nx   = word_valid ? SHIFT : LOAD;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // Abort never swallows a word on its way out.
        if (abort) begin
            state_nx   = IDLE;
            word_ready = 1'b0;
        end
        accept = word_valid && word_ready;
        busy   = (state == LOAD) || (state == SHIFT);
        done   = (state == DONE);
    end

    always_ff @(posedge prog_clk) begin
        if (prog_rst) begin
            sbuf      <= '0;
            wbits     <= '0;
            bit_count <= '0;
            prog_in   <= 1'b0;
            prog_en   <= 1'b0;
        end else begin
            prog_en <= (state_nx == SHIFT);
            if (state == IDLE && start && !abort) begin
                bit_count <= '0;
            end
            if (state == SHIFT) begin
                bit_count <= bit_count + BCW'(1);
                sbuf      <= sbuf >> 1;
                wbits     <= wbits - WBW'(1);
                // On a word's last bit prog_in holds through any stall.
                if (!last_bit) prog_in <= sbuf[1];
            end
            if (accept) begin
                sbuf    <= word_data;
                wbits   <= wbits_ld;
                prog_in <= word_data[0];
            end
        end
    end

endmodule

// File: tb/tb_bitstream_loader.sv
// Randomized bench for bitstream_loader at 552/32 and 69/32 chain sizes.
// Serial output is compared with a bit-list reference built from the words.
module tb_bitstream_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        start;
    logic        abort;
    logic        word_valid;
    logic [31:0] word_data;

    logic        st_a, ab_a, wv_a, wr_a, pi_a, pe_a, busy_a, done_a;
    logic        st_b, ab_b, wv_b, wr_b, pi_b, pe_b, busy_b, done_b;
    logic [9:0]  bc_a;
    logic [6:0]  bc_b;

    logic        word_ready, prog_in, prog_en, busy, done;
    int          bit_count;

    assign st_a = start & ~sel;
    assign ab_a = abort & ~sel;
    assign wv_a = word_valid & ~sel;
    assign st_b = start & sel;
    assign ab_b = abort & sel;
    assign wv_b = word_valid & sel;

    assign word_ready = sel ? wr_b : wr_a;
    assign prog_in    = sel ? pi_b : pi_a;
    assign prog_en    = sel ? pe_b : pe_a;
    assign busy       = sel ? busy_b : busy_a;
    assign done       = sel ? done_b : done_a;
    assign bit_count  = sel ? int'(bc_b) : int'(bc_a);

    bitstream_loader #(.CHAIN_LEN(552), .WORD_W(32)) u_dut (
        .prog_clk   (clk),
        .prog_rst   (rst),
        .start      (st_a),
        .abort      (ab_a),
        .word_valid (wv_a),
        .word_data  (word_data),
        .word_ready (wr_a),
        .prog_in    (pi_a),
        .prog_en    (pe_a),
        .busy       (busy_a),
        .done       (done_a),
        .bit_count  (bc_a)
    );

    bitstream_loader #(.CHAIN_LEN(69), .WORD_W(32)) u_dut69 (
        .prog_clk   (clk),
        .prog_rst   (rst),
        .start      (st_b),
        .abort      (ab_b),
        .word_valid (wv_b),
        .word_data  (word_data),
        .word_ready (wr_b),
        .prog_in    (pi_b),
        .prog_en    (pe_b),
        .busy       (busy_b),
        .done       (done_b),
        .bit_count  (bc_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string tag, longint g, longint e);
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, g, e);
        end
    endtask

    logic        got[$];
    logic        refq[$];
    logic [31:0] words[20];
    int base = 0;
    int done_cnt = 0;
    int hs_cnt = 0;
    int gap_cnt = 0;
    int bc_bad = 0;
    int hs0, d0, g0, fin_bc, gap_bc;
    logic done_rdy;

    // bit_count must equal the number of prog_en cycles seen this load.
    always @(negedge clk) begin
        if (busy && bit_count != int'(got.size()) - base) bc_bad++;
        if (prog_en && !busy) bc_bad++;
        if (prog_en) got.push_back(prog_in);
        else if (busy && int'(got.size()) > base) gap_cnt++;
        if (done) done_cnt++;
        if (word_valid && word_ready) hs_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(int nwo, int gap_at, int gap_len,
                        int abort_at, int start_at);
        int idx;
        int gl;
        bit hs;
        bit fin;
        base     = got.size();
        hs0      = hs_cnt;
        d0       = done_cnt;
        g0       = gap_cnt;
        fin_bc   = -1;
        gap_bc   = -1;
        done_rdy = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        idx = 0;
        gl  = gap_len;
        fin = 1'b0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            if (abort_at >= 0 && busy && bit_count == abort_at) begin
                abort      = 1'b1;
                word_valid = 1'b0;
                step();
                abort = 1'b0;
                @(negedge clk);
                chk("abort_en", prog_en, 0);
                chk("abort_busy", busy, 0);
                step();
                fin = 1'b1;
            end else begin
                start      = (start_at >= 0 && bit_count == start_at);
                word_valid = (idx < nwo) && !(idx == gap_at && gl > 0);
                word_data  = words[idx < 20 ? idx : 0];
                @(negedge clk);
                hs = word_valid && word_ready;
                if (idx == gap_at && gl > 0 && word_ready) begin
                    gl--;
                    gap_bc = bit_count;
                end
                if (done) begin
                    fin      = 1'b1;
                    fin_bc   = bit_count;
                    done_rdy = word_ready;
                end
                step();
                if (hs) idx++;
            end
        end
        start = 1'b0;
        if (!fin) chk("timeout", 0, 1);
    endtask

    task automatic cmp_seq(string tag);
        int n;
        int e;
        n = int'(got.size()) - base;
        chk({tag, "_en_cycles"}, n, refq.size());
        e = 0;
        for (int i = 0; i < refq.size() && i < n; i++) begin
            if (got[base + i] !== refq[i]) e++;
        end
        chk({tag, "_bit_errs"}, e, 0);
    endtask

    task automatic post(string tag, int exp_hs, int exp_gap);
        repeat (3) step();
        cmp_seq(tag);
        chk({tag, "_handshakes"}, hs_cnt - hs0, exp_hs);
        chk({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_en_gap"}, gap_cnt - g0, exp_gap);
        chk({tag, "_final_bc"}, fin_bc, refq.size());
        chk({tag, "_bc_track"}, bc_bad, 0);
    endtask

    task automatic build_clb();
        logic [68:0] pat;
        logic [31:0] wd;
        pat = 69'({$urandom(), $urandom(), $urandom()});
        refq.delete();
        for (int i = 0; i < 552; i++) refq.push_back(pat[i % 69]);
        for (int w = 0; w < 18; w++) begin
            wd = $urandom();
            for (int b = 0; b < 32; b++) begin
                if (w * 32 + b < 552) wd[b] = refq[w * 32 + b];
            end
            words[w] = wd;
        end
    endtask

    task automatic build_short();
        logic [31:0] wd;
        for (int w = 0; w < 4; w++) words[w] = $urandom();
        refq.delete();
        for (int i = 0; i < 69; i++) begin
            wd = words[i / 32];
            refq.push_back(wd[i % 32]);
        end
    endtask

    initial begin
        rst        = 1'b1;
        sel        = 1'b0;
        start      = 1'b1;
        abort      = 1'b0;
        word_valid = 1'b1;
        word_data  = $urandom();
        build_clb();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {prog_in, prog_en, busy, done}, 0);
        chk("rst_ready", word_ready, 0);
        chk("rst_bc", bit_count, 0);
        step();
        rst        = 1'b0;
        start      = 1'b0;
        word_valid = 1'b0;
        @(negedge clk);
        chk("rst_hs", hs_cnt, 0);
        step();

        feed(18, -1, 0, -1, 100);
        post("full", 18, 0);

        feed(18, 2, 5, -1, -1);
        post("stall", 18, 5);
        chk("stall_bc", gap_bc, 64);

        feed(18, -1, 0, 300, -1);
        repeat (4) step();
        chk("abort_done", done_cnt - d0, 0);

        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("start_abort_busy", busy, 0);
        step();

        feed(18, -1, 0, -1, -1);
        post("restart", 18, 0);

        sel = 1'b1;
        step();
        build_short();
        feed(4, -1, 0, -1, -1);
        chk("short_done_ready", done_rdy, 0);
        @(negedge clk);
        chk("short_idle_ready", word_ready, 0);
        step();
        word_valid = 1'b0;
        post("short", 3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bitstream_loader.md
# bitstream_loader

Word-to-serial configuration loader that sits directly upstream of a CLB row's programming shift chain. Accepts 32-bit configuration words over a valid/ready stream and shifts them LSB-first onto `prog_in`, qualified by `prog_en`, for exactly `CHAIN_LEN` bits. For an `OddRow` that is 8 CLBs × 69 bits = 552. The block stalls the chain cleanly when words are late, supports abort, and pulses `done` when the full chain is loaded.

## Interface
- `CHAIN_LEN`, 552, total configuration bits to shift; range 1..65535.
- `WORD_W`, 32, input word width; range 2..64.
- `prog_clk` in 1: sole clock; all logic on posedge.
- `prog_rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a load. Honoured only in IDLE.
- `abort` in 1: terminate the load; return to IDLE. Has priority over `start`.
- `word_valid` in 1: `word_data` is valid.
- `word_data` in `WORD_W`: config word; bit 0 is shifted first.
- `word_ready` out 1: loader accepts a word this cycle.
- `prog_in` out 1: serial config bit to the chain; registered.
- `prog_en` out 1: chain shift enable; registered. The chain samples `prog_in` on a posedge when `prog_en`=1.
- `busy` out 1: high in LOAD or SHIFT.
- `done` out 1: one-cycle pulse after the final bit.
- `bit_count` out clog2(`CHAIN_LEN`+1): number of bits presented to the chain so far.

## Operation
- FSM states:
  - IDLE: `start` (and not `abort`) moves to LOAD; `bit_count` clears to 0.
  - LOAD: waiting for a word; `prog_en`=0.
  - SHIFT: shifting the current word.
  - DONE: lasts one cycle, `done`=1; then moves to IDLE.
- A word is accepted when `word_valid` and `word_ready` are both high at a posedge. It loads a `WORD_W`-bit shift buffer and a per-word bit counter: `wbits` = min(`WORD_W`, `CHAIN_LEN` − `bit_count`).
- In SHIFT, each cycle presents `buf[0]` with `prog_en`=1, then:
  - shifts the buffer right by 1;
  - decrements `wbits`;
  - increments `bit_count`.
- `word_ready` is combinational:
  - high in LOAD;
  - high in SHIFT on the last bit of a word (`wbits`=1) when `bit_count`+1 < `CHAIN_LEN`. This gives zero-bubble back-to-back streaming.
  - low otherwise, including IDLE and DONE. Surplus words are never consumed.
- Last-bit handling in SHIFT:
  - If a word is accepted on the last bit, stay in SHIFT with the new word.
  - If no word is accepted on the last bit, go to LOAD.
  - If the last bit is bit `CHAIN_LEN`−1, go to DONE.
- Final word: bits above `CHAIN_LEN` mod `WORD_W` are discarded. At 552/32, word 17 contributes bits [7:0] only.
- Word count per load: ceil(`CHAIN_LEN`/`WORD_W`), which is 18 at defaults.
- `abort` in any state → IDLE next cycle. `prog_en`=0 and `busy`=0 from that cycle, no `done`. The chain contents are left partial; a new `start` restarts from bit 0.
- `start` outside IDLE is ignored.
- Reset values: state IDLE, `prog_in`=0, `prog_en`=0, `busy`=0, `done`=0, `bit_count`=0, buffer 0.

## Timing
- Word accepted at posedge k → `prog_en`=1 and `prog_in`=`word_data[0]` in cycle k+1. The chain captures that bit at posedge k+1.
- With `word_valid` held high, `prog_en` is high for exactly `CHAIN_LEN` consecutive cycles.
- Bit i (global index) appears `i` cycles after the first-word acceptance cycle + 1.
- `done` is asserted in the cycle after the last `prog_en`=1 cycle. `busy` falls the same cycle `done` rises.
- Stall: if `word_valid` is low on the last bit of a word, `prog_en`=0 from the next cycle. It stays 0 until the cycle after the acceptance edge. `prog_in` holds its value and `bit_count` holds.
- `prog_rst` mid-SHIFT: all outputs take reset values in the cycle after the reset edge; `prog_en` never glitches high.

## Test plan
- Reset held 3 cycles with `word_valid`=1 and `start`=1 → all outputs 0, `word_ready`=0, no word consumed.
- Start, then continuous 18 words, each being the 69-bit CLB pattern replicated ×8 and packed LSB-first → `prog_en` high for exactly 552 consecutive cycles, the `prog_in` sequence equals the packed bits 0..551, exactly 18 handshakes, `done` pulses once, `bit_count`=552.
- Same stream, `word_valid` dropped for 5 cycles before word 2 → `prog_en` low exactly 5 cycles, `bit_count` frozen at 64 during the gap, the serial bit sequence is identical to the no-stall case.
- `abort` asserted while `bit_count`=300 → `prog_en`=0 and `busy`=0 next cycle, no `done`; a following `start` plus 18 words yields the full 552-bit sequence from bit 0.
- `start` pulsed during SHIFT → no effect, `bit_count` continues monotonically. `start` and `abort` together in IDLE → stays IDLE.
- `CHAIN_LEN`=69, `WORD_W`=32 → 3 words accepted, 69 `prog_en` cycles, upper 27 bits of word 2 never appear on `prog_in`; a 4th offered word is not accepted (`word_ready`=0).
